// File: rtl/down_counter.sv
// Loadable down counter/timer with terminal-count pulse, one-shot or auto-reload.
// Programmable delay/period generator companion to the free-running up counter.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Load always wins and restarts; tc defaults low so it can never stretch past one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count      <= load_val;
        reload_reg <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (state == RUN) begin
        if (en && count > ONE) begin
          count <= count - ONE;
        end else if (en && count == ONE) begin
          count <= '0;
          tc    <= 1'b1;
          if (!mode) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else if (count == '0 && !mode) begin
          // Auto-reload dropped while parked at zero: stop without reloading.
          state <= IDLE;
          busy  <= 1'b0;
        end else if (en && count == '0) begin
          count <= reload_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model.
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       mode;
  logic [7:0] count;
  logic       tc;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int m_count;
  int m_reload;
  bit m_run;
  bit m_tc;

  down_counter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".count"}, int'(count), m_count);
    checkOutput({tag, ".tc"}, int'(tc), int'(m_tc));
    checkOutput({tag, ".busy"}, int'(busy), int'(m_run));
  endtask

  task automatic modelReset();
    m_count  = 0;
    m_reload = 0;
    m_run    = 0;
    m_tc     = 0;
  endtask

  // Timer behaviour in plain terms: a loaded value ticks down on enabled cycles,
  // hitting zero fires tc; auto-reload restarts from the loaded value one tick later.
  task automatic modelStep();
    int n_count;
    bit n_run;
    n_count = m_count;
    n_run   = m_run;
    m_tc    = 0;
    if (load) begin
      n_count  = int'(load_val);
      m_reload = int'(load_val);
      n_run    = (load_val != 0);
    end else if (m_run) begin
      if (en && m_count >= 2) n_count = m_count - 1;
      else if (en && m_count == 1) begin
        n_count = 0;
        m_tc    = 1;
        n_run   = mode;
      end else if (m_count == 0 && !mode) n_run = 0;
      else if (en && m_count == 0) n_count = m_reload;
    end
    m_count = n_count;
    m_run   = n_run;
  endtask

  task automatic applyStimulus(input bit l, input int lv, input bit e, input bit md, input string tag);
    load     = l;
    load_val = 8'(lv);
    en       = e;
    mode     = md;
    @(posedge clk);
    if (rst) modelStep();
    else modelReset();
    #1;
    checkAll(tag);
  endtask

  task automatic asyncResetPulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0;
    load_val = '0;
    en = 1'b0;
    mode = 1'b0;
    modelReset();

    // Reset held while load/en toggle
    applyStimulus(1, 77, 1, 1, "reset0");
    applyStimulus(0, 12, 0, 0, "reset1");
    applyStimulus(1, 33, 1, 0, "reset2");
    rst = 1'b1;
    applyStimulus(0, 0, 1, 0, "idleAfterReset");

    // One-shot from 5
    applyStimulus(1, 5, 0, 0, "oneShotLoad");
    checkOutput("oneShotLoadVal", int'(count), 5);
    for (int i = 4; i >= 0; i--) begin
      applyStimulus(0, 0, 1, 0, "oneShot");
      checkOutput("oneShotSeq", int'(count), i);
    end
    checkOutput("oneShotTc", int'(tc), 1);
    checkOutput("oneShotBusyDrop", int'(busy), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "oneShotAfter");

    // Auto-reload from 3, period 4
    applyStimulus(1, 3, 1, 1, "autoLoad");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 1, 1, "auto");
      checkOutput("autoSeq", int'(count), (2 - i % 4 + 4) % 4);
      checkOutput("autoTc", int'(tc), int'(i % 4 == 2));
    end

    // Enable gaps
    applyStimulus(1, 4, 0, 0, "gapLoad");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, bit'(i % 2 == 0), 0, "gap");

    // Priority / restart
    applyStimulus(1, 4, 0, 0, "prioLoad");
    applyStimulus(0, 0, 1, 0, "prioRun");
    applyStimulus(0, 0, 1, 0, "prioRun");
    checkOutput("prioAtTwo", int'(count), 2);
    applyStimulus(1, 9, 1, 0, "prioReload");
    checkOutput("prioNine", int'(count), 9);
    applyStimulus(1, 0, 1, 0, "prioZero");
    checkOutput("prioZeroBusy", int'(busy), 0);

    // Async reset mid-run
    applyStimulus(1, 200, 0, 1, "arLoad");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, "arRun");
    checkOutput("arCount", int'(count), 190);
    asyncResetPulse("arPulse");
    applyStimulus(0, 0, 1, 1, "arAfter");

    // Randomized traffic, including occasional async resets
    for (int i = 0; i < 600; i++) begin
      bit l;
      int lv;
      l  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      if ($urandom_range(0, 12) == 0) mode = ~mode;
      applyStimulus(l, lv, bit'($urandom_range(0, 3) != 0), mode, "rand");
      if ($urandom_range(0, 120) == 0) asyncResetPulse("randReset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
